// File: rtl/pipe_id_fwd.sv
// pipe_id_fwd -- decode stage for the 5-stage core.
//
// Holds the IF/ID register, a 2R1W register file with write-through,
// EX/MEM/WB operand forwarding, load-use hazard detection and a
// registered ID/EX bundle.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         IF handshake; in_instr, in_pc fetched data
//   flush                     kill IF/ID and ID/EX (taken branch/jump)
//   ex_hold                   downstream stall, freezes IF/ID and ID/EX
//   ex_valid/ex_memrd/ex_wa/ex_result   EX stage state for forwarding
//   mem_valid/mem_wa/mem_result         MEM stage state for forwarding
//   wb_wen/wb_ovf/wb_wa/wb_wd           writeback into the register file
//   out_*                     registered ID/EX bundle
//   stall_cnt                 saturating count of load-use stall cycles
module pipe_id_fwd #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_instr,
    input  logic [DW-1:0]    in_pc,
    input  logic             flush,
    input  logic             ex_hold,
    input  logic             ex_valid,
    input  logic             ex_memrd,
    input  logic [AW-1:0]    ex_wa,
    input  logic [DW-1:0]    ex_result,
    input  logic             mem_valid,
    input  logic [AW-1:0]    mem_wa,
    input  logic [DW-1:0]    mem_result,
    input  logic             wb_wen,
    input  logic             wb_ovf,
    input  logic [AW-1:0]    wb_wa,
    input  logic [DW-1:0]    wb_wd,
    output logic             out_valid,
    output logic [DW-1:0]    out_pc,
    output logic [DW-1:0]    out_instr,
    output logic [DW-1:0]    out_rd1,
    output logic [DW-1:0]    out_rd2,
    output logic [DW-1:0]    out_imm_s,
    output logic [DW-1:0]    out_imm_z,
    output logic [DW-1:0]    out_shamt,
    output logic [AW-1:0]    out_wa,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int DEPTH = 2 ** AW;

    // Map a 5-bit instruction register field onto AW bits: zero-extend
    // when AW>5, keep the low AW bits when AW<5.
    function automatic logic [AW-1:0] fld(input logic [4:0] f);
        logic [31:0] t;
        t = {27'b0, f};
        return t[AW-1:0];
    endfunction

    logic            ifid_valid;
    logic [DW-1:0]   ifid_instr;
    logic [DW-1:0]   ifid_pc;
    logic [DW-1:0]   rf [DEPTH];

    logic [AW-1:0]   rs, rt, wa_dec;
    logic [5:0]      op;
    logic            hazard;
    logic            rf_w;
    logic [DW-1:0]   rd1, rd2;

    assign op     = ifid_instr[31:26];
    assign rs     = fld(ifid_instr[25:21]);
    assign rt     = fld(ifid_instr[20:16]);
    assign wa_dec = (op == 6'd0) ? fld(ifid_instr[15:11]) : fld(ifid_instr[20:16]);

    // rt is compared even for formats that never read it; a spurious
    // stall is cheaper than decoding which instructions use rt.
    assign hazard   = ifid_valid && ex_valid && ex_memrd && (ex_wa != '0) &&
                      ((ex_wa == rs) || (ex_wa == rt));
    assign in_ready = !ex_hold && !hazard;
    assign rf_w     = wb_wen && !wb_ovf && (wb_wa != '0);

    // Youngest producer wins. A load in EX has no data yet; the hazard
    // logic stalls instead, so EX only forwards non-load results.
    function automatic logic [DW-1:0] fwd(input logic [AW-1:0] a);
        if (a == '0)                                   return '0;
        else if (ex_valid && !ex_memrd && ex_wa == a)  return ex_result;
        else if (mem_valid && mem_wa == a)             return mem_result;
        else if (rf_w && wb_wa == a)                   return wb_wd;
        else                                           return rf[a];
    endfunction

    always_comb begin
        rd1 = fwd(rs);
        rd2 = fwd(rt);
    end

    // Register file; entry 0 is never written so it reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
        end else if (rf_w) begin
            rf[wb_wa] <= wb_wd;
        end
    end

    // IF/ID register
    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
            ifid_pc    <= '0;
        end else if (flush) begin
            ifid_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            ifid_valid <= 1'b1;
            ifid_instr <= in_instr;
            ifid_pc    <= in_pc;
        end
    end

    // ID/EX register; flush beats ex_hold, ex_hold beats hazard.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_instr <= '0;
            out_rd1   <= '0;
            out_rd2   <= '0;
            out_imm_s <= '0;
            out_imm_z <= '0;
            out_shamt <= '0;
            out_wa    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (!ex_hold) begin
            if (hazard) begin
                out_valid <= 1'b0;
            end else begin
                out_valid <= ifid_valid;
                out_pc    <= ifid_pc;
                out_instr <= ifid_instr;
                out_rd1   <= rd1;
                out_rd2   <= rd2;
                out_imm_s <= {{(DW-16){ifid_instr[15]}}, ifid_instr[15:0]};
                out_imm_z <= {{(DW-16){1'b0}}, ifid_instr[15:0]};
                out_shamt <= {{(DW-5){1'b0}}, ifid_instr[10:6]};
                out_wa    <= wa_dec;
            end
        end
    end

    // Counts only cycles where the bubble is actually inserted.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (hazard && !ex_hold && !flush && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_pipe_id_fwd.sv
// Randomized bench for pipe_id_fwd against a behavioural decode-stage model.
module tb_pipe_id_fwd;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_ready2;
    logic [31:0] in_instr, in_pc;
    logic        flush, ex_hold;
    logic        ex_valid, ex_memrd;
    logic [4:0]  ex_wa, mem_wa, wb_wa;
    logic [31:0] ex_result, mem_result, wb_wd;
    logic        mem_valid, wb_wen, wb_ovf;
    logic        out_valid, out_valid2;
    logic [31:0] out_pc, out_instr, out_rd1, out_rd2, out_imm_s, out_imm_z, out_shamt;
    logic [31:0] out_pc2, out_instr2, out_rd12, out_rd22, out_imm_s2, out_imm_z2, out_shamt2;
    logic [4:0]  out_wa, out_wa2;
    logic [15:0] stall_cnt;
    logic [1:0]  stall_cnt2;

    always #5 clk = ~clk;

    pipe_id_fwd #(.DW(32), .AW(5), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .ex_hold(ex_hold),
        .ex_valid(ex_valid), .ex_memrd(ex_memrd), .ex_wa(ex_wa), .ex_result(ex_result),
        .mem_valid(mem_valid), .mem_wa(mem_wa), .mem_result(mem_result),
        .wb_wen(wb_wen), .wb_ovf(wb_ovf), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
        .out_rd1(out_rd1), .out_rd2(out_rd2), .out_imm_s(out_imm_s),
        .out_imm_z(out_imm_z), .out_shamt(out_shamt), .out_wa(out_wa),
        .stall_cnt(stall_cnt)
    );

    // Narrow counter copy to exercise saturation.
    pipe_id_fwd #(.DW(32), .AW(5), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .ex_hold(ex_hold),
        .ex_valid(ex_valid), .ex_memrd(ex_memrd), .ex_wa(ex_wa), .ex_result(ex_result),
        .mem_valid(mem_valid), .mem_wa(mem_wa), .mem_result(mem_result),
        .wb_wen(wb_wen), .wb_ovf(wb_ovf), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .out_valid(out_valid2), .out_pc(out_pc2), .out_instr(out_instr2),
        .out_rd1(out_rd12), .out_rd2(out_rd22), .out_imm_s(out_imm_s2),
        .out_imm_z(out_imm_z2), .out_shamt(out_shamt2), .out_wa(out_wa2),
        .stall_cnt(stall_cnt2)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference model state
    logic [31:0] m_rf [32];
    logic        m_iv = 1'b0;
    logic [31:0] m_ii = '0, m_ip = '0;
    logic        e_v;
    logic [31:0] e_pc, e_instr, e_rd1, e_rd2, e_ims, e_imz, e_sh;
    logic [4:0]  e_wa;
    int          e_cnt, e_cnt2;

    function automatic logic [31:0] opnd(input logic [4:0] a);
        if (a == 0) return 0;
        if (ex_valid && !ex_memrd && ex_wa == a) return ex_result;
        if (mem_valid && mem_wa == a) return mem_result;
        if (wb_wen && !wb_ovf && wb_wa != 0 && wb_wa == a) return wb_wd;
        return m_rf[a];
    endfunction

    // One clock: predict from current inputs, clock, compare.
    task automatic step();
        logic [4:0] rs, rt;
        logic hz, rdy;
        logic [31:0] n_rd1, n_rd2;
        #1;
        rs  = m_ii[25:21];
        rt  = m_ii[20:16];
        hz  = m_iv && ex_valid && ex_memrd && ex_wa != 0 && (ex_wa == rs || ex_wa == rt);
        rdy = !ex_hold && !hz;
        n_rd1 = opnd(rs);
        n_rd2 = opnd(rt);
        if (!rst) begin
            chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
            chk("in_ready_c2", {31'b0, in_ready2}, {31'b0, rdy});
        end
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 0;
            m_iv = 0; m_ii = 0; m_ip = 0;
            e_v = 0; e_pc = 0; e_instr = 0; e_rd1 = 0; e_rd2 = 0;
            e_ims = 0; e_imz = 0; e_sh = 0; e_wa = 0; e_cnt = 0; e_cnt2 = 0;
        end else begin
            if (flush) begin
                e_v = 0;
            end else if (!ex_hold) begin
                if (hz) e_v = 0;
                else begin
                    e_v = m_iv; e_pc = m_ip; e_instr = m_ii;
                    e_rd1 = n_rd1; e_rd2 = n_rd2;
                    e_imz = m_ii & 32'hFFFF;
                    e_ims = m_ii[15] ? (m_ii | 32'hFFFF0000) : (m_ii & 32'hFFFF);
                    e_sh  = (m_ii >> 6) & 32'h1F;
                    e_wa  = (m_ii[31:26] == 0) ? m_ii[15:11] : m_ii[20:16];
                end
            end
            if (hz && !ex_hold && !flush) begin
                if (e_cnt < 65535) e_cnt++;
                if (e_cnt2 < 3) e_cnt2++;
            end
            if (flush) m_iv = 0;
            else if (in_valid && rdy) begin
                m_iv = 1; m_ii = in_instr; m_ip = in_pc;
            end
            if (wb_wen && !wb_ovf && wb_wa != 0) m_rf[wb_wa] = wb_wd;
        end
        chk("out_valid", {31'b0, out_valid}, {31'b0, e_v});
        chk("out_pc", out_pc, e_pc);
        chk("out_instr", out_instr, e_instr);
        chk("out_rd1", out_rd1, e_rd1);
        chk("out_rd2", out_rd2, e_rd2);
        chk("out_imm_s", out_imm_s, e_ims);
        chk("out_imm_z", out_imm_z, e_imz);
        chk("out_shamt", out_shamt, e_sh);
        chk("out_wa", {27'b0, out_wa}, {27'b0, e_wa});
        chk("stall_cnt", {16'b0, stall_cnt}, e_cnt);
        chk("stall_cnt_w2", {30'b0, stall_cnt2}, e_cnt2);
    endtask

    task automatic idle();
        rst = 0; in_valid = 0; in_instr = 0; in_pc = 0; flush = 0; ex_hold = 0;
        ex_valid = 0; ex_memrd = 0; ex_wa = 0; ex_result = 0;
        mem_valid = 0; mem_wa = 0; mem_result = 0;
        wb_wen = 0; wb_ovf = 0; wb_wa = 0; wb_wd = 0;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1; in_instr = instr; in_pc = pc;
        step();
        in_valid = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        step(); step();
        rst = 0;
        chk("rst_valid", {31'b0, out_valid}, 0);
        chk("rst_cnt", {16'b0, stall_cnt}, 0);

        // preload r1=5, r2=7, then addu $3,$1,$2
        wb_wen = 1; wb_wa = 1; wb_wd = 5; step();
        wb_wa = 2; wb_wd = 7; step();
        wb_wen = 0;
        issue(32'h00221821, 32'h100);
        step();
        chk("addu_valid", {31'b0, out_valid}, 1);
        chk("addu_rd1", out_rd1, 5);
        chk("addu_rd2", out_rd2, 7);
        chk("addu_wa", {27'b0, out_wa}, 3);

        // load-use: lw $4 in EX, addu $5,$4,$4 in ID
        issue(32'h00842821, 32'h104);
        ex_valid = 1; ex_memrd = 1; ex_wa = 4;
        step();
        chk("lu_bubble", {31'b0, out_valid}, 0);
        chk("lu_cnt", {16'b0, stall_cnt}, 1);
        ex_valid = 0; ex_memrd = 0;
        mem_valid = 1; mem_wa = 4; mem_result = 32'h1234;
        step();
        chk("lu_issue", {31'b0, out_valid}, 1);
        chk("lu_fwd", out_rd1, 32'h1234);
        idle();

        // EX beats MEM on r6
        issue(32'h00C03821, 32'h108);
        ex_valid = 1; ex_wa = 6; ex_result = 32'h10;
        mem_valid = 1; mem_wa = 6; mem_result = 32'h20;
        step();
        chk("ex_prio", out_rd1, 32'h10);
        ex_valid = 0;
        step();
        chk("mem_fwd", out_rd1, 32'h20);
        idle();

        // WB write-through on r9, then overflowed write is dropped
        issue(32'h01200821, 32'h10C);
        wb_wen = 1; wb_wa = 9; wb_wd = 32'hDEADBEEF;
        step();
        chk("wb_thru", out_rd1, 32'hDEADBEEF);
        wb_ovf = 1; wb_wd = 32'h55;
        step();
        chk("wb_ovf", out_rd1, 32'hDEADBEEF);
        idle();
        step();
        chk("wb_ovf_rf", out_rd1, 32'hDEADBEEF);

        // flush wins over ex_hold and a live hazard on r9
        ex_valid = 1; ex_memrd = 1; ex_wa = 9; ex_hold = 1; flush = 1;
        step();
        chk("flush_valid", {31'b0, out_valid}, 0);
        chk("flush_cnt", {16'b0, stall_cnt}, 1);
        ex_hold = 0; flush = 0;
        step();
        chk("flush_ready", {31'b0, in_ready}, 1);
        idle();

        // r0 stays zero; addiu immediate extension
        wb_wen = 1; wb_wa = 0; wb_wd = 32'hFFFF;
        issue(32'h00000821, 32'h110);
        wb_wen = 0;
        step();
        chk("r0_read", out_rd1, 0);
        issue(32'h24028000, 32'h114);
        step();
        chk("imm_s", out_imm_s, 32'hFFFF8000);
        chk("imm_z", out_imm_z, 32'h00008000);
        chk("addiu_wa", {27'b0, out_wa}, 2);

        // five back-to-back load-use stalls saturate the 2-bit counter
        issue(32'h00842821, 32'h118);
        ex_valid = 1; ex_memrd = 1; ex_wa = 4;
        repeat (5) step();
        chk("sat_cnt2", {30'b0, stall_cnt2}, 3);
        idle();

        // random traffic; small register sets make hazards/forwards common
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 199) == 0);
            in_valid   = $urandom_range(0, 1);
            in_instr   = {($urandom_range(0, 1) ? 6'd0 : 6'($urandom_range(0, 63))),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
            in_pc      = $urandom;
            flush      = ($urandom_range(0, 9) == 0);
            ex_hold    = ($urandom_range(0, 5) == 0);
            ex_valid   = $urandom_range(0, 1);
            ex_memrd   = $urandom_range(0, 1);
            ex_wa      = 5'($urandom_range(0, 7));
            ex_result  = $urandom;
            mem_valid  = $urandom_range(0, 1);
            mem_wa     = 5'($urandom_range(0, 7));
            mem_result = $urandom;
            wb_wen     = $urandom_range(0, 1);
            wb_ovf     = ($urandom_range(0, 3) == 0);
            wb_wa      = 5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
            wb_wd      = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
